// File: rtl/fp_mul_ci.sv
// Sequential IEEE-754 binary32 multiplier with a start/done handshake.
// Fixed 26-enabled-edge latency for every operand class, including specials.
module fp_mul_ci (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [47:0] acc_q, acc_d;
   logic        done_q, done_d;

   logic [23:0] ma, mb;
   logic [47:0] addend;
   logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [22:0] mant_pre;
   logic        guard, sticky, round_up, carry;
   logic [23:0] mant_rnd;
   logic signed [9:0] exp_n;
   logic [31:0] packed_res;

   assign ma     = {1'b1, a_q[22:0]};
   assign mb     = {1'b1, b_q[22:0]};
   assign addend = ma[cnt_q] ? ({24'd0, mb} << cnt_q) : 48'd0;

   assign sign   = a_q[31] ^ b_q[31];
   assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
   assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
   assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
   assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
   // Denormal operands count as zero.
   assign a_zero = (a_q[30:23] == 8'h00);
   assign b_zero = (b_q[30:23] == 8'h00);

   // Normalise on product bit 47, then round-to-nearest-even.
   always_comb begin
      mant_pre = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
      guard    = acc_q[47] ? acc_q[23]    : acc_q[22];
      sticky   = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
      round_up = guard & (sticky | mant_pre[0]);
      mant_rnd = {1'b0, mant_pre} + {23'd0, round_up};
      carry    = mant_rnd[23];
      exp_n    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
               - 10'sd127 + $signed({9'd0, acc_q[47]}) + $signed({9'd0, carry});
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         packed_res = 32'h7FC00000;
      else if (a_inf || b_inf)
         packed_res = {sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         packed_res = {sign, 31'd0};
      else if (exp_n >= 10'sd255)
         packed_res = {sign, 8'hFF, 23'd0};
      else if (exp_n <= 10'sd0)
         packed_res = {sign, 31'd0};
      else
         packed_res = {sign, exp_n[7:0], mant_rnd[22:0]};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = dataa;
               b_d     = datab;
               cnt_d   = 5'd0;
               acc_d   = 48'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d = acc_q + addend;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
               cnt_d   = 5'd0;
               state_d = NORM;
            end
         end
         NORM: begin
            result_d = packed_res;
            state_d  = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         cnt_q    <= 5'd0;
         acc_q    <= 48'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
      end else if (clk_en) begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_fp_mul_ci.sv
// Bench for fp_mul_ci: vector table plus hand sequences for clock-enable
// stalls, ignored starts, back-to-back issue and mid-operation reset.
module tb_fp_mul_ci;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa, datab;
   logic        done;
   logic [31:0] result;

   fp_mul_ci dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .dataa  (dataa),
      .datab  (datab),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int en_edges = 0;
   logic last_en = 1'b0;
   logic prev_done = 1'b0;

   logic [31:0] exp_q[$];
   int          t0e_q[$];
   int          t0c_q[$];
   int          extra_q[$];

   logic [31:0] want_y;
   int          want_e, want_c, want_x;

   always @(posedge clk) begin
      cyc++;
      if (clk_en && !reset) en_edges++;
      last_en = clk_en;
   end

   // Monitor: every rising done pops one expected result and checks latency.
   always @(negedge clk) begin
      if (!reset) begin
         if (done && !prev_done) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL spurious_done got=%h want=no done", result);
            end else begin
               want_y = exp_q.pop_front();
               want_e = t0e_q.pop_front();
               want_c = t0c_q.pop_front();
               want_x = extra_q.pop_front();
               if (result !== want_y || (en_edges - want_e) != 26 ||
                   (cyc - want_c) != 26 + want_x) begin
                  bad++;
                  $display("FAIL result got=%h want=%h lat_en=%0d want=26 lat_cyc=%0d want=%0d",
                           result, want_y, en_edges - want_e, cyc - want_c, 26 + want_x);
               end
            end
         end
         if (prev_done && last_en) begin
            total++;
            if (done) begin
               bad++;
               $display("FAIL done_width got=1 want=0 after one enabled cycle");
            end
         end
      end
      prev_done = done;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input int extra);
      dataa = a;
      datab = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(y);
      t0e_q.push_back(en_edges);
      t0c_q.push_back(cyc);
      extra_q.push_back(extra);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL timeout got pending=%0d want=0", exp_q.size());
         exp_q.delete(); t0e_q.delete(); t0c_q.delete(); extra_q.delete();
      end
   endtask

   task automatic wait_done_hi(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL done_wait got=0 want=1 within %0d cycles", budget);
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000};
      vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
      vecs[2]  = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'h7FC00000};
      vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
      vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
      vecs[5]  = '{32'h00000002, 32'h00000017, 32'h00000000};
      vecs[6]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002};
      vecs[7]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004};
      vecs[8]  = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000};
      vecs[9]  = '{32'h3F7FFFFF, 32'h3F800001, 32'h3F800000};
      vecs[10] = '{32'h7F000000, 32'h40000000, 32'h7F800000};
      vecs[11] = '{32'h7F000000, 32'h3F800000, 32'h7F000000};
      vecs[12] = '{32'h00800000, 32'h3F800000, 32'h00800000};
      vecs[13] = '{32'h00800000, 32'h00800000, 32'h00000000};
      vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000};
      vecs[15] = '{32'h80000000, 32'h7F800000, 32'h7FC00000};

      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      dataa  = 32'd0;
      datab  = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      // Start presented at the first enabled edge after reset release.
      reset = 1'b0;
      issue(32'h3FC00000, 32'h40000000, 32'h40400000, 0);
      wait_drain(40);

      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(vecs[i].a, vecs[i].b, vecs[i].y, 0);
         wait_drain(40);
      end

      // Five disabled cycles inside MUL stretch wall-clock latency by five.
      issue(32'h3FC00000, 32'h40000000, 32'h40400000, 5);
      repeat (8) @(negedge clk);
      clk_en = 1'b0;
      dataa  = 32'h12345678;
      repeat (5) @(negedge clk);
      clk_en = 1'b1;
      wait_drain(60);
      check("hold_result", result, 32'h40400000);

      // Extra starts while busy must be ignored.
      issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 0);
      repeat (3) @(negedge clk);
      dataa = 32'h3F800000;
      datab = 32'h3F800000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_drain(40);
      repeat (30) @(negedge clk);
      check("ignored_start_result", result, 32'hC0C00000);

      // Back-to-back: new start while done is high.
      issue(32'h3FC00000, 32'h40000000, 32'h40400000, 0);
      wait_done_hi(40);
      issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 0);
      wait_drain(40);

      // Reset mid-operation aborts without a done.
      repeat (2) @(negedge clk);
      issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      exp_q.delete(); t0e_q.delete(); t0c_q.delete(); extra_q.delete();
      @(negedge clk);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      reset = 1'b0;
      repeat (35) @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_result_held", result, 32'd0);
      issue(32'h3FC00000, 32'h40000000, 32'h40400000, 0);
      wait_drain(40);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_mul_ci.md
FP_MUL_CI -- requirements
Module: fp_mul_ci

Interface
REQ-001 SHALL have no parameters; the operand format is fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk_en  input  1  clock qualifier; when low, all internal state and outputs hold.
REQ-005 start  input  1  one-cycle request strobe; operands are valid in the same cycle.
REQ-006 dataa  input  32  binary32 operand A.
REQ-007 datab  input  32  binary32 operand B.
REQ-008 done  output  1  registered one-cycle completion pulse.
REQ-009 result  output  32  binary32 product; valid while done is high, held afterwards.

Function
REQ-010 SHALL be the responder (multi-cycle custom-instruction slave) for a sequential single-precision multiply.
REQ-011 SHALL use the states IDLE, MUL, NORM and DONE.
REQ-012 IDLE -> MUL SHALL occur on an edge where clk_en=1 and start=1; both operands SHALL be captured at that edge (edge T0).
REQ-013 MUL SHALL run a 24-iteration shift-add mantissa multiply (implicit 1 restored) into a 48-bit product, one iteration per enabled edge.
REQ-014 After the 24th iteration the FSM SHALL go MUL -> NORM; NORM SHALL normalise, round and pack the result in one enabled edge, then go NORM -> DONE.
REQ-015 In DONE, done=1 for exactly one enabled cycle, then the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be fixed for all operand classes: done rises at enabled edge T0+26.
REQ-017 start SHALL be ignored in MUL, NORM and DONE; there is no queuing.
REQ-018 start=1 in IDLE in the cycle right after done SHALL be accepted (back-to-back issue).
REQ-019 When clk_en=0, the FSM, counter, datapath, done and result SHALL all hold; latency counts enabled edges only.
REQ-020 Sign SHALL be the XOR of the operand signs, except for NaN results.
REQ-021 Exponent SHALL be computed at 10-bit signed width as ea+eb-127, plus 1 if the product MSB (bit 47) is set.
REQ-022 Rounding SHALL be round-to-nearest-even, using guard and sticky bits from the discarded product bits; a mantissa carry-out SHALL increment the exponent.
REQ-023 Overflow (final exponent >= 255) SHALL give signed infinity, 0x7F800000 or 0xFF800000.
REQ-024 Underflow (final exponent <= 0) SHALL flush to signed zero; no denormals are produced.
REQ-025 Denormal inputs (exp=0) SHALL be treated as signed zero.
REQ-026 Any NaN input, or infinity x zero, SHALL give the canonical NaN 0x7FC00000.
REQ-027 Infinity x nonzero finite SHALL give signed infinity; zero x finite SHALL give signed zero.
REQ-028 Special-case detection MAY bypass the datapath, but SHALL still obey REQ-016.
REQ-029 result SHALL update only at the NORM -> DONE edge and SHALL hold its value until the next completion.

Reset
REQ-030 While reset is high: state=IDLE, done=0, result=0x00000000, iteration counter=0, captured operands=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation immediately; no done SHALL follow for the aborted request.
REQ-032 A start sampled at the first enabled edge after reset deasserts SHALL be accepted.

Verification
REQ-033 dataa=0x3FC00000, datab=0x40000000, start pulse -> done at T0+26, result=0x40400000.
REQ-034 Sign and exact-value cases: 0xC0000000 x 0x40400000 -> 0xC0C00000; 0x3F800001 x 0x3F800001 -> 0x3F800002 (RNE).
REQ-035 Special-value cases, each with fixed 26-cycle latency:
- 0xFFFFFFFA x 0xFFFFFFFA -> 0x7FC00000;
- 0x7F800000 x 0x00000000 -> 0x7FC00000;
- 0x7F000000 x 0x7F000000 -> 0x7F800000;
- 0x00000002 x 0x00000017 -> 0x00000000.
REQ-036 Hold clk_en low for 5 cycles during MUL -> done delayed by exactly 5 cycles, result unchanged (0x40400000).
REQ-037 Extra start pulses during MUL -> ignored; exactly one done. A start in the cycle after done -> second correct result 26 edges later.
REQ-038 Reset pulsed at T0+10 -> done stays 0, result=0x00000000; a new start after reset completes normally.
